// File: rtl/iis_stream_bridge.sv
// iis_stream_bridge: moves L/R sample pairs between the I2S core's per-channel
// 32-bit FIFOs and a valid/ready word stream. RX turns MSB-aligned FIFO words
// into sign-extended right-justified words (L then R); TX packs an L/R stream
// pair into MSB-aligned words and pushes both FIFOs together.
module iis_stream_bridge #(
  parameter int FIFO_LAT = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        clear,
  input  logic [1:0]  sample_width,
  input  logic [31:0] rx_data_l,
  input  logic [31:0] rx_data_r,
  input  logic        rx_data_l_empty,
  input  logic        rx_data_r_empty,
  output logic        rx_data_drain,
  output logic [31:0] m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic [31:0] tx_data_l,
  output logic [31:0] tx_data_r,
  input  logic        tx_data_l_full,
  input  logic        tx_data_r_full,
  output logic        tx_data_fill,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [15:0] rx_frames,
  output logic [15:0] tx_frames,
  output logic        err_sticky
);

  typedef enum logic [1:0] {RX_IDLE, RX_L, RX_R} rx_state_t;
  typedef enum logic [1:0] {TX_L, TX_R, TX_PUSH} tx_state_t;

  localparam int            CW    = $clog2(FIFO_LAT + 1) + 1;
  localparam logic [CW-1:0] LAT_C = CW'(FIFO_LAT);

  rx_state_t     rx_state, rx_next;
  tx_state_t     tx_state, tx_next;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic          rx_cnt_done, tx_cnt_done;
  logic [31:0]   rx_hold_l, rx_hold_r;
  logic [4:0]    shamt;
  logic [31:0]   rx_word, tx_word;
  logic          live, run;
  logic          rx_done, tx_acc_l, tx_acc_r, tx_err;

  assign rx_cnt_done = (rx_cnt >= LAT_C);
  assign tx_cnt_done = (tx_cnt >= LAT_C);
  // live keeps every handshake output low while reset is asserted
  assign run         = enable & ~clear & live;
  assign rx_word     = (rx_state == RX_R) ? rx_hold_r : rx_hold_l;
  assign tx_word     = s_data << shamt;

  // Justification shift: 32 - sample width.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    shamt = 5'd0;
    case (sample_width)
      2'd0:    shamt = 5'd16;
      2'd1:    shamt = 5'd8;
      default: shamt = 5'd0;
    endcase
  end

  // Output word: arithmetic shift keeps the sample sign in the upper bits.
  always_comb begin
    m_data = '0;
    if (rx_state != RX_IDLE) m_data = 32'($signed(rx_word) >>> shamt);
  end

  // RX next-state and strobes: pop both FIFOs together, then emit L and R.
  always_comb begin
    rx_next       = rx_state;
    rx_data_drain = 1'b0;
    m_valid       = 1'b0;
    m_last        = 1'b0;
    rx_done       = 1'b0;
    if (!run) begin
      rx_next = RX_IDLE;
    end else begin
      case (rx_state)
        RX_IDLE: if (rx_cnt_done && !rx_data_l_empty && !rx_data_r_empty) begin
          rx_data_drain = 1'b1;
          rx_next       = RX_L;
        end
        RX_L: begin
          m_valid = 1'b1;
          if (m_ready) rx_next = RX_R;
        end
        RX_R: begin
          m_valid = 1'b1;
          m_last  = 1'b1;
          if (m_ready) begin
            rx_next = RX_IDLE;
            rx_done = 1'b1;
          end
        end
        default: rx_next = RX_IDLE;
      endcase
    end
  end

  // TX next-state and strobes: collect L then R, then push once both FIFOs have room.
  always_comb begin
    tx_next      = tx_state;
    s_ready      = 1'b0;
    tx_data_fill = 1'b0;
    tx_acc_l     = 1'b0;
    tx_acc_r     = 1'b0;
    tx_err       = 1'b0;
    if (!run) begin
      tx_next = TX_L;
    end else begin
      case (tx_state)
        TX_L: begin
          s_ready = 1'b1;
          if (s_valid) begin
            if (s_last) begin
              tx_err = 1'b1;
            end else begin
              tx_acc_l = 1'b1;
              tx_next  = TX_R;
            end
          end
        end
        TX_R: begin
          s_ready = 1'b1;
          if (s_valid) begin
            tx_acc_r = 1'b1;
            tx_err   = ~s_last;
            tx_next  = TX_PUSH;
          end
        end
        TX_PUSH: if (tx_cnt_done && !tx_data_l_full && !tx_data_r_full) begin
          tx_data_fill = 1'b1;
          tx_next      = TX_L;
        end
        default: tx_next = TX_L;
      endcase
    end
  end

  // State registers and settle counters; TX settle restarts while a FIFO reports full.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      live     <= 1'b0;
      rx_state <= RX_IDLE;
      tx_state <= TX_L;
      rx_cnt   <= '0;
      tx_cnt   <= '0;
    end else begin
      live     <= 1'b1;
      rx_state <= rx_next;
      tx_state <= tx_next;
      if (rx_next != rx_state)  rx_cnt <= '0;
      else if (!rx_cnt_done)    rx_cnt <= rx_cnt + CW'(1);
      if (tx_next != tx_state || (tx_state == TX_PUSH && (tx_data_l_full || tx_data_r_full)))
        tx_cnt <= '0;
      else if (!tx_cnt_done)
        tx_cnt <= tx_cnt + CW'(1);
    end
  end

  // Holding registers for both directions.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_hold_l <= '0;
      rx_hold_r <= '0;
      tx_data_l <= '0;
      tx_data_r <= '0;
    end else begin
      if (rx_data_drain) begin
        rx_hold_l <= rx_data_l;
        rx_hold_r <= rx_data_r;
      end
      if (tx_acc_l) tx_data_l <= tx_word;
      if (tx_acc_r) tx_data_r <= tx_word;
    end
  end

  // Frame counters and framing-error flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_frames  <= '0;
      tx_frames  <= '0;
      err_sticky <= 1'b0;
    end else if (clear) begin
      rx_frames  <= '0;
      tx_frames  <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (rx_done)      rx_frames  <= rx_frames + 16'd1;
      if (tx_data_fill) tx_frames  <= tx_frames + 16'd1;
      if (tx_err)       err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_iis_stream_bridge.sv
// tb_iis_stream_bridge: scoreboard bench for the I2S stream bridge.
module tb_iis_stream_bridge;
  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rstn, enable, clear;
  logic [1:0]  sample_width;
  logic [31:0] rx_data_l, rx_data_r;
  logic        rx_data_l_empty, rx_data_r_empty, rx_data_drain;
  logic [31:0] m_data;
  logic        m_valid, m_last, m_ready;
  logic [31:0] tx_data_l, tx_data_r;
  logic        tx_data_l_full, tx_data_r_full, tx_data_fill;
  logic [31:0] s_data;
  logic        s_valid, s_last, s_ready;
  logic [15:0] rx_frames, tx_frames;
  logic        err_sticky;

  int n_cmp = 0;
  int n_err = 0;
  int drains = 0;
  int fills = 0;
  logic [32:0] rx_exp[$];
  logic [63:0] tx_exp[$];
  logic [32:0] src_q[$];

  iis_stream_bridge #(.FIFO_LAT(LAT)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .clear(clear), .sample_width(sample_width),
    .rx_data_l(rx_data_l), .rx_data_r(rx_data_r),
    .rx_data_l_empty(rx_data_l_empty), .rx_data_r_empty(rx_data_r_empty),
    .rx_data_drain(rx_data_drain), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready), .tx_data_l(tx_data_l), .tx_data_r(tx_data_r),
    .tx_data_l_full(tx_data_l_full), .tx_data_r_full(tx_data_r_full),
    .tx_data_fill(tx_data_fill), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .rx_frames(rx_frames), .tx_frames(tx_frames), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rx_model(input logic [31:0] x, input logic [1:0] w);
    case (w)
      2'd0:    return {{16{x[31]}}, x[31:16]};
      2'd1:    return {{8{x[31]}}, x[31:8]};
      default: return x;
    endcase
  endfunction

  function automatic logic [31:0] tx_model(input logic [31:0] s, input logic [1:0] w);
    case (w)
      2'd0:    return {s[15:0], 16'h0};
      2'd1:    return {s[23:0], 8'h0};
      default: return s;
    endcase
  endfunction

  // One clock: score handshakes at the falling edge, then update the FIFO/source models.
  task automatic cycle();
    logic        pop_rx, acc;
    logic [32:0] e;
    logic [63:0] t;
    pop_rx = 1'b0;
    @(negedge clk);
    if (m_valid && m_ready) begin
      n_cmp++;
      if (rx_exp.size() == 0) begin
        n_err++;
        $display("FAIL rx_unexpected: got last=%b data=%h, required no word", m_last, m_data);
      end else begin
        e = rx_exp.pop_front();
        if ({m_last, m_data} !== e) begin
          n_err++;
          $display("FAIL rx_word: got last=%b data=%h, required last=%b data=%h",
                   m_last, m_data, e[32], e[31:0]);
        end
      end
    end
    if (rx_data_drain) begin
      drains++;
      pop_rx = 1'b1;
    end
    if (tx_data_fill) begin
      fills++;
      n_cmp++;
      if (tx_exp.size() == 0) begin
        n_err++;
        $display("FAIL tx_unexpected: got l=%h r=%h, required no fill", tx_data_l, tx_data_r);
      end else begin
        t = tx_exp.pop_front();
        if ({tx_data_l, tx_data_r} !== t) begin
          n_err++;
          $display("FAIL tx_pair: got l=%h r=%h, required l=%h r=%h",
                   tx_data_l, tx_data_r, t[63:32], t[31:0]);
        end
      end
    end
    acc = s_valid && s_ready;
    @(posedge clk);
    #1;
    if (pop_rx) begin
      rx_data_l_empty = 1'b1;
      rx_data_r_empty = 1'b1;
    end
    if (acc && src_q.size() > 0) void'(src_q.pop_front());
    if (src_q.size() > 0) begin
      s_valid = 1'b1;
      {s_last, s_data} = src_q[0];
    end else begin
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = '0;
    end
  endtask

  task automatic load_rx(input logic [31:0] l, input logic [31:0] r);
    rx_data_l = l;
    rx_data_r = r;
    rx_data_l_empty = 1'b0;
    rx_data_r_empty = 1'b0;
    rx_exp.push_back({1'b0, rx_model(l, sample_width)});
    rx_exp.push_back({1'b1, rx_model(r, sample_width)});
  endtask

  task automatic send_pair(input logic [31:0] l, input logic [31:0] r);
    src_q.push_back({1'b0, l});
    src_q.push_back({1'b1, r});
    tx_exp.push_back({tx_model(l, sample_width), tx_model(r, sample_width)});
  endtask

  task automatic set_width(input logic [1:0] w);
    enable = 1'b0;
    cycle();
    sample_width = w;
    cycle();
    enable = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; enable = 1'b1; clear = 1'b0; sample_width = 2'd0;
    rx_data_l = '0; rx_data_r = '0; rx_data_l_empty = 1'b1; rx_data_r_empty = 1'b1;
    m_ready = 1'b0; tx_data_l_full = 1'b0; tx_data_r_full = 1'b0;
    s_data = '0; s_valid = 1'b0; s_last = 1'b0;
    #12;
    n_cmp++;
    if ({m_valid, m_last, rx_data_drain, tx_data_fill, s_ready, err_sticky} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_strobes: got %b, required 000000",
               {m_valid, m_last, rx_data_drain, tx_data_fill, s_ready, err_sticky});
    end
    n_cmp++;
    if ({m_data, tx_data_l, tx_data_r} !== 96'h0) begin
      n_err++;
      $display("FAIL reset_data: got m=%h l=%h r=%h, required all 0", m_data, tx_data_l, tx_data_r);
    end
    n_cmp++;
    if ({rx_frames, tx_frames} !== 32'h0) begin
      n_err++;
      $display("FAIL reset_frames: got rx=%0d tx=%0d, required 0 0", rx_frames, tx_frames);
    end
    #8 rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_rx_w16();
    load_rx(32'h8001_2345, 32'h7FFF_0000);
    m_ready = 1'b1;
    for (int i = 0; i < 20 && drains == 0; i++) cycle();
    n_cmp++;
    if (m_valid !== 1'b1 || drains != 1) begin
      n_err++;
      $display("FAIL rx_latency: got m_valid=%b drains=%0d one cycle after drain, required 1 1", m_valid, drains);
    end
    for (int i = 0; i < 20 && rx_exp.size() > 0; i++) cycle();
    n_cmp++;
    if (rx_exp.size() != 0 || rx_frames !== 16'd1 || drains != 1) begin
      n_err++;
      $display("FAIL rx_w16_done: got left=%0d frames=%0d drains=%0d, required 0 1 1",
               rx_exp.size(), rx_frames, drains);
    end
  endtask

  task automatic test_tx_w24();
    set_width(2'd1);
    send_pair(32'h0012_3456, 32'hFF80_0000);
    for (int i = 0; i < 30 && fills == 0; i++) cycle();
    n_cmp++;
    if (fills != 1 || tx_frames !== 16'd1 || tx_data_l !== 32'h1234_5600 || tx_data_r !== 32'h8000_0000) begin
      n_err++;
      $display("FAIL tx_w24: got fills=%0d frames=%0d l=%h r=%h, required 1 1 12345600 80000000",
               fills, tx_frames, tx_data_l, tx_data_r);
    end
  endtask

  task automatic test_rx_backpressure();
    int d0;
    logic [31:0] exp_l;
    m_ready = 1'b0;
    load_rx(32'hFEDC_BA98, 32'h0123_4567);
    exp_l = rx_model(32'hFEDC_BA98, sample_width);
    for (int i = 0; i < 20 && !m_valid; i++) cycle();
    load_rx(32'h7F00_0001, 32'h80FF_FFFF);
    d0 = drains;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_cmp++;
      if (m_valid !== 1'b1 || m_last !== 1'b0 || m_data !== exp_l || drains != d0) begin
        n_err++;
        $display("FAIL rx_hold[%0d]: got v=%b last=%b data=%h drains=%0d, required 1 0 %h %0d",
                 i, m_valid, m_last, m_data, drains, exp_l, d0);
      end
    end
    m_ready = 1'b1;
    cycle();
    cycle();
    n_cmp++;
    if (drains != d0) begin
      n_err++;
      $display("FAIL rx_no_early_drain: got drains=%0d, required %0d", drains, d0);
    end
    for (int i = 0; i < 30 && rx_exp.size() > 0; i++) cycle();
    n_cmp++;
    if (rx_exp.size() != 0 || drains != d0 + 1 || rx_frames !== 16'd3) begin
      n_err++;
      $display("FAIL rx_bp_done: got left=%0d drains=%0d frames=%0d, required 0 %0d 3",
               rx_exp.size(), drains, rx_frames, d0 + 1);
    end
  endtask

  task automatic test_tx_full();
    int f0, n;
    set_width(2'd0);
    tx_data_r_full = 1'b1;
    f0 = fills;
    send_pair(32'h0000_ABCD, 32'h1234_1234);
    for (int i = 0; i < 20 && src_q.size() > 0; i++) cycle();
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_cmp++;
      if (s_ready !== 1'b0 || fills != f0) begin
        n_err++;
        $display("FAIL tx_full_wait[%0d]: got s_ready=%b fills=%0d, required 0 %0d", i, s_ready, fills, f0);
      end
    end
    tx_data_r_full = 1'b0;
    n = 0;
    for (int i = 0; i < 10 && fills == f0; i++) begin
      cycle();
      n++;
    end
    n_cmp++;
    if (n != LAT + 1 || fills != f0 + 1 || tx_frames !== 16'd2) begin
      n_err++;
      $display("FAIL tx_full_release: got cycles=%0d fills=%0d frames=%0d, required %0d %0d 2",
               n, fills, tx_frames, LAT + 1, f0 + 1);
    end
  endtask

  task automatic test_framing_error();
    int f0;
    set_width(2'd1);
    f0 = fills;
    src_q.push_back({1'b1, 32'h0011_1111});
    send_pair(32'h00AB_CDEF, 32'h00FE_DCBA);
    for (int i = 0; i < 20 && src_q.size() > 2; i++) cycle();
    n_cmp++;
    if (err_sticky !== 1'b1) begin
      n_err++;
      $display("FAIL err_set: got err_sticky=%b, required 1", err_sticky);
    end
    for (int i = 0; i < 30 && fills == f0; i++) cycle();
    n_cmp++;
    if (fills != f0 + 1 || err_sticky !== 1'b1 || tx_frames !== 16'd3) begin
      n_err++;
      $display("FAIL err_pair: got fills=%0d err=%b frames=%0d, required %0d 1 3",
               fills, err_sticky, tx_frames, f0 + 1);
    end
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    n_cmp++;
    if (err_sticky !== 1'b0 || tx_frames !== 16'd0 || rx_frames !== 16'd0) begin
      n_err++;
      $display("FAIL err_clear: got err=%b tx=%0d rx=%0d, required 0 0 0", err_sticky, tx_frames, rx_frames);
    end
  endtask

  task automatic test_clear_mid_rx();
    int d0;
    set_width(2'd0);
    m_ready = 1'b0;
    load_rx(32'h1234_0000, 32'hABCD_0000);
    for (int i = 0; i < 20 && !m_valid; i++) cycle();
    m_ready = 1'b1;
    cycle();
    m_ready = 1'b0;
    n_cmp++;
    if (m_valid !== 1'b1 || m_last !== 1'b1) begin
      n_err++;
      $display("FAIL rx_in_r: got v=%b last=%b, required 1 1", m_valid, m_last);
    end
    void'(rx_exp.pop_back());
    rx_data_l_empty = 1'b0;
    rx_data_r_empty = 1'b1;
    d0 = drains;
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    n_cmp++;
    if (m_valid !== 1'b0 || rx_frames !== 16'd0) begin
      n_err++;
      $display("FAIL rx_clear: got v=%b frames=%0d, required 0 0", m_valid, rx_frames);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) cycle();
    n_cmp++;
    if (drains != d0 || m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rx_single_empty: got drains=%0d v=%b, required %0d 0", drains, m_valid, d0);
    end
    rx_data_l_empty = 1'b1;
  endtask

  task automatic test_enable_drop_tx();
    int f0;
    f0 = fills;
    src_q.push_back({1'b0, 32'h0000_0011});
    for (int i = 0; i < 20 && src_q.size() > 0; i++) cycle();
    enable = 1'b0;
    cycle();
    enable = 1'b1;
    send_pair(32'h0000_2222, 32'h0000_3333);
    for (int i = 0; i < 30 && fills == f0; i++) cycle();
    n_cmp++;
    if (fills != f0 + 1 || tx_frames !== 16'd1 || tx_exp.size() != 0) begin
      n_err++;
      $display("FAIL tx_enable_drop: got fills=%0d frames=%0d pending=%0d, required %0d 1 0",
               fills, tx_frames, tx_exp.size(), f0 + 1);
    end
  endtask

  initial begin
    test_reset();
    test_rx_w16();
    test_tx_w24();
    test_rx_backpressure();
    test_tx_full();
    test_framing_error();
    test_clear_mid_rx();
    test_enable_drop_tx();
    for (int i = 0; i < 5; i++) cycle();
    n_cmp++;
    if (rx_exp.size() != 0 || tx_exp.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got rx_left=%0d tx_left=%0d, required 0 0", rx_exp.size(), tx_exp.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
